check_node_unit: RTL

CHECK_NODE_UNIT -- requirements
Module: check_node_unit

---
 rtl/check_node_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/check_node_unit.sv
// check_node_unit -- two-stage min-sum LDPC check node for degree-4 checks.
//
// Stage 1 registers per-input signs, the smallest and second-smallest input
// magnitudes (min1/min2), the index of min1 and the total sign. Stage 2 forms
// the four extrinsic check-to-variable messages and the parity flag.
// Both stages use a valid/ready pipeline.
//
// Build option: define OFFSET_MIN_SUM_EN to select offset-min-sum. min1 and
// min2 are then reduced by OFFSET, floored at 0, before stage 2. When the macro
// is undefined, the unit is a plain min-sum node. Latency and handshake are the
// same in both builds.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   L1..L4              variable-to-check messages, W-bit two's complement
//   in_valid/in_ready   input handshake; in_ready does not depend on in_valid
//   I1..I4              check-to-variable messages, W-bit two's complement
//   parity              XOR of input sign bits (1 = check unsatisfied)
//   out_valid/out_ready output handshake
//   clr                 synchronous clear of err_cnt; wins over an increment
//   err_cnt             saturating count of output handshakes with parity=1
module check_node_unit #(
  parameter int unsigned W      = 16,
  parameter int unsigned OFFSET = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] L1,
  input  logic [W-1:0] L2,
  input  logic [W-1:0] L3,
  input  logic [W-1:0] L4,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] I1,
  output logic [W-1:0] I2,
  output logic [W-1:0] I3,
  output logic [W-1:0] I4,
  output logic         parity,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         clr,
  output logic [15:0]  err_cnt
);

  localparam int unsigned MW = W - 1;  // magnitude width
  localparam logic [MW-1:0] MagMax = {MW{1'b1}};

`ifdef OFFSET_MIN_SUM_EN
  localparam bit OffsetEn = 1'b1;
`else
  localparam bit OffsetEn = 1'b0;
`endif
  localparam logic [MW-1:0] OffAmt = OffsetEn ? MW'(OFFSET) : '0;

  // Handshake control
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic adv1, adv2, load1, load2;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign load1    = adv1 && in_valid;
  assign load2    = adv2 && s1_valid_q;

  // Stage 1 combinational: sign/magnitude and min search
  logic [W-1:0]  l_in [4];
  logic [MW-1:0] mag  [4];
  logic [3:0]    sgn;

  assign l_in[0] = L1;
  assign l_in[1] = L2;
  assign l_in[2] = L3;
  assign l_in[3] = L4;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sgn[k] = l_in[k][W-1];
      if (!sgn[k]) begin
        mag[k] = l_in[k][MW-1:0];
      end else if (l_in[k] == {1'b1, {MW{1'b0}}}) begin
        // Most negative value has no positive counterpart; saturate.
        mag[k] = MagMax;
      end else begin
        // |L| < 2^MW here, so negating the low MW bits gives |L| exactly.
        mag[k] = -l_in[k][MW-1:0];
      end
    end
  end

  logic [MW-1:0] min1_c, min2_c;
  logic [1:0]    idx1_c;

  always_comb begin
    min1_c = mag[0];
    idx1_c = 2'd0;
    // Strict '<' keeps the lowest index among equal minima.
    for (int k = 1; k < 4; k++) begin
      if (mag[k] < min1_c) begin
        min1_c = mag[k];
        idx1_c = 2'(k);
      end
    end
    // Excluding only the idx1 slot makes min2 equal min1 on a tie.
    min2_c = MagMax;
    for (int k = 0; k < 4; k++) begin
      if (2'(k) != idx1_c && mag[k] < min2_c) begin
        min2_c = mag[k];
      end
    end
  end

  // Stage 1 registers
  logic [MW-1:0] min1_q, min1_d, min2_q, min2_d;
  logic [1:0]    idx1_q, idx1_d;
  logic [3:0]    sgn_q, sgn_d;
  logic          tsign_q, tsign_d;

  always_comb begin
    s1_valid_d = adv1 ? in_valid : s1_valid_q;
    min1_d     = min1_q;
    min2_d     = min2_q;
    idx1_d     = idx1_q;
    sgn_d      = sgn_q;
    tsign_d    = tsign_q;
    if (load1) begin
      min1_d  = min1_c;
      min2_d  = min2_c;
      idx1_d  = idx1_c;
      sgn_d   = sgn;
      tsign_d = ^sgn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      min1_q     <= '0;
      min2_q     <= '0;
      idx1_q     <= '0;
      sgn_q      <= '0;
      tsign_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      min1_q     <= min1_d;
      min2_q     <= min2_d;
      idx1_q     <= idx1_d;
      sgn_q      <= sgn_d;
      tsign_q    <= tsign_d;
    end
  end

  // Offset correction, floored at zero. With OffAmt=0, this is the identity.
  logic [MW-1:0] min1_eff, min2_eff;

  assign min1_eff = (min1_q > OffAmt) ? (min1_q - OffAmt) : '0;
  assign min2_eff = (min2_q > OffAmt) ? (min2_q - OffAmt) : '0;

  // Stage 2: extrinsic messages
  logic [MW-1:0] mag_o [4];
  logic [W-1:0]  ext   [4];
  logic [W-1:0]  i_c   [4];
  logic [W-1:0]  i_q   [4];
  logic [W-1:0]  i_d   [4];
  logic          parity_q, parity_d;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      mag_o[k] = (idx1_q == 2'(k)) ? min2_eff : min1_eff;
      ext[k]   = {1'b0, mag_o[k]};
      i_c[k]   = (tsign_q ^ sgn_q[k]) ? -ext[k] : ext[k];
      i_d[k]   = load2 ? i_c[k] : i_q[k];
    end
    out_valid_d = adv2 ? s1_valid_q : out_valid_q;
    parity_d    = load2 ? tsign_q : parity_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      parity_q    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        i_q[k] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      parity_q    <= parity_d;
      for (int k = 0; k < 4; k++) begin
        i_q[k] <= i_d[k];
      end
    end
  end

  assign I1        = i_q[0];
  assign I2        = i_q[1];
  assign I3        = i_q[2];
  assign I4        = i_q[3];
  assign parity    = parity_q;
  assign out_valid = out_valid_q;

  // Unsatisfied-check counter
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
    end else if (out_valid_q && out_ready && parity_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule
